seg_scan_driver: RTL and testbench
==================================

Name: seg_scan_driver

Overview:
- Parametrised, time-multiplexed multi-digit hex display driver for common-anode/cathode 7-segment banks.
- Next generation of the single-digit combinational hex decoder: adds N-digit scanning, tear-free frame-synchronous value update, leading-zero suppression, anti-ghost blanking and selectable output polarity.
- Sits between datapath registers and board display pins.

Parameters:
- NUM_DIGITS, 4: digits scanned (1..8); digit 0 = least significant nibble.
- PRESCALE, 50000: clocks per digit slot (>=2).
- SEG_ACTIVE_LOW, 1: 1 = segment/dp pins low-true; 0 = high-true.
- DIG_ACTIVE_LOW, 1: same convention for digit selects.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- enable  in  1  1 = scan; 0 = hold counters, all outputs inactive.
- load  in  1  one-cycle strobe; capture value/dp_in into shadow.
- value  in  4*NUM_DIGITS  packed hex nibbles.
- dp_in  in  NUM_DIGITS  decimal point per digit.
- lz_blank  in  1  leading-zero suppression enable.
- seg  out  7  {a,b,c,d,e,f,g}, bit 6 = a.
- dp  out  1  decimal point.
- dig_sel  out  NUM_DIGITS  one-hot digit enable (per polarity).
- frame_done  out  1  one-cycle pulse at frame wrap.

Behaviour:
- Clock: single clock clk. Reset: rst_n, asynchronous assert, active-low; all flops cleared immediately on assert.
- Reset values: prescale count 0, digit index 0, shadow/display regs 0, pending 0, frame_done 0; seg, dp and dig_sel all at inactive level.
- Prescale counter counts 0..PRESCALE-1. At terminal count it returns to 0 and the index advances. Index wraps NUM_DIGITS-1 -> 0.
- frame_done pulses on the cycle the index wraps.
- Display update:
  - load writes shadow and sets pending.
  - At frame wrap, if pending: display <= shadow, pending <= 0.
  - Simultaneous load and wrap: display <= value/dp_in directly (bypass), shadow also updated, pending <= 0.
  - A load mid-frame never changes the displayed digits until the wrap.
- Outputs are registered, 1-cycle latency from index/count.
- Anti-ghost: during slot count 0 all dig_sel inactive; counts 1..PRESCALE-1 drive the selected digit.
- Decode: standard hex glyphs 0-F (A, b, C, d, E, F).
- Leading-zero suppression (lz_blank=1): digit i blanks its segments if its nibble and all higher nibbles are 0. Digit 0 is never suppressed. dp still follows dp_in on a suppressed digit.
- enable=0: counters and index hold, outputs inactive next cycle; load/pending logic still operates. Scanning resumes from the held state.
- Reset mid-frame: immediate return to the reset state; pending load is lost.

Optional Feature:
- SEG_BRIGHTNESS_EN
- Defined: adds input bright[3:0]. Within each slot, dig_sel is active only while count*16 < (bright+1)*PRESCALE, and never at count 0.
- Undefined: no port; full-slot drive as above.

Decomposition:
- Package seg_pkg: glyph constants for 0-F in {a..g} order, segment bit indices, polarity helper constants.
- Sub-module hex_seg_decode: 4-bit nibble to 7-bit active-high glyph, purely combinational. Polarity inversion is applied in seg_scan_driver.

Test Plan (NUM_DIGITS=4, PRESCALE=4, both polarities active-low):
- Reset: assert rst_n=0 mid-slot -> same cycle seg=7'h7F, dp=1, dig_sel=4'hF; after release first frame_done occurs 16 clocks after scanning starts.
- Load 16'h1234, wait one wrap -> slot of digit 0: dig_sel=4'hE, seg=7'h4C ("4"); digit 3: dig_sel=4'h7, seg=7'h4F ("1"); dig_sel=4'hF at every count 0.
- Load 16'h0080 with lz_blank=1 -> digits 3,2 seg=7'h7F; digit 1 seg=7'h00 ("8"); digit 0 seg=7'h01 ("0").
- Load 16'hAAAA mid-frame -> remaining slots of the current frame still show the old value; new value is shown from the next frame.
- Load coincident with frame_done -> the loaded value is displayed starting at digit 0 of the new frame, with no one-frame delay.
- enable=0 for 10 cycles -> outputs inactive, index unchanged; scanning resumes in the same slot.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment scan driver: glyphs in {a..g} order
// (bit 6 = a), segment bit positions and polarity helpers.
package seg_pkg;

  localparam int unsigned NIB_W = 4;
  localparam int unsigned SEG_W = 7;

  localparam int unsigned SEG_A = 6;
  localparam int unsigned SEG_B = 5;
  localparam int unsigned SEG_C = 4;
  localparam int unsigned SEG_D = 3;
  localparam int unsigned SEG_E = 2;
  localparam int unsigned SEG_F = 1;
  localparam int unsigned SEG_G = 0;

  // Active-high glyphs
  localparam logic [SEG_W-1:0] GLYPH_0 = 7'h7E;
  localparam logic [SEG_W-1:0] GLYPH_1 = 7'h30;
  localparam logic [SEG_W-1:0] GLYPH_2 = 7'h6D;
  localparam logic [SEG_W-1:0] GLYPH_3 = 7'h79;
  localparam logic [SEG_W-1:0] GLYPH_4 = 7'h33;
  localparam logic [SEG_W-1:0] GLYPH_5 = 7'h5B;
  localparam logic [SEG_W-1:0] GLYPH_6 = 7'h5F;
  localparam logic [SEG_W-1:0] GLYPH_7 = 7'h70;
  localparam logic [SEG_W-1:0] GLYPH_8 = 7'h7F;
  localparam logic [SEG_W-1:0] GLYPH_9 = 7'h7B;
  localparam logic [SEG_W-1:0] GLYPH_A = 7'h77;
  localparam logic [SEG_W-1:0] GLYPH_B = 7'h1F;
  localparam logic [SEG_W-1:0] GLYPH_C = 7'h4E;
  localparam logic [SEG_W-1:0] GLYPH_D = 7'h3D;
  localparam logic [SEG_W-1:0] GLYPH_E = 7'h4F;
  localparam logic [SEG_W-1:0] GLYPH_F = 7'h47;

  localparam logic [SEG_W-1:0] SEG_ALL_OFF_HI = 7'h00;
  localparam logic [SEG_W-1:0] SEG_ALL_ON_HI  = 7'h7F;

endpackage

// File: rtl/hex_seg_decode.sv
// Combinational hex nibble to active-high 7-segment glyph.
module hex_seg_decode
  import seg_pkg::*;
(
  input  logic [NIB_W-1:0] nib_i,
  output logic [SEG_W-1:0] glyph_c_o
);

  always_comb begin
    glyph_c_o = GLYPH_F;
    case (nib_i)
      4'h0: glyph_c_o = GLYPH_0;
      4'h1: glyph_c_o = GLYPH_1;
      4'h2: glyph_c_o = GLYPH_2;
      4'h3: glyph_c_o = GLYPH_3;
      4'h4: glyph_c_o = GLYPH_4;
      4'h5: glyph_c_o = GLYPH_5;
      4'h6: glyph_c_o = GLYPH_6;
      4'h7: glyph_c_o = GLYPH_7;
      4'h8: glyph_c_o = GLYPH_8;
      4'h9: glyph_c_o = GLYPH_9;
      4'hA: glyph_c_o = GLYPH_A;
      4'hB: glyph_c_o = GLYPH_B;
      4'hC: glyph_c_o = GLYPH_C;
      4'hD: glyph_c_o = GLYPH_D;
      4'hE: glyph_c_o = GLYPH_E;
      default: glyph_c_o = GLYPH_F;
    endcase
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed N-digit hex display driver with frame-synchronous update,
// leading-zero blanking and anti-ghost slot gaps. Optional macro SEG_BRIGHTNESS_EN.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS     = 4,
  parameter int unsigned PRESCALE       = 50000,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          DIG_ACTIVE_LOW = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        enable,
  input  logic                        load,
  input  logic [NIB_W*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]       dp_in,
  input  logic                        lz_blank,
`ifdef SEG_BRIGHTNESS_EN
  input  logic [3:0]                  bright,
`endif
  output logic [SEG_W-1:0]            seg,
  output logic                        dp,
  output logic [NUM_DIGITS-1:0]       dig_sel,
  output logic                        frame_done
);

  localparam int unsigned CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned VAL_W = NIB_W * NUM_DIGITS;
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(PRESCALE - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [SEG_W-1:0]      SEG_INV  = {SEG_W{SEG_ACTIVE_LOW}};
  localparam logic [NUM_DIGITS-1:0] DIG_INV  = {NUM_DIGITS{DIG_ACTIVE_LOW}};

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [VAL_W-1:0]      shadow_q, shadow_d, disp_q, disp_d;
  logic [NUM_DIGITS-1:0] shadow_dp_q, shadow_dp_d, disp_dp_q, disp_dp_d;
  logic                  pending_q, pending_d;
  logic [SEG_W-1:0]      seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [NUM_DIGITS-1:0] dig_q, dig_d;
  logic                  frame_q, frame_d;

  logic                  wrap_c;
  logic                  slot_on_c;
  logic                  blank_c;
  logic                  dp_bit_c;
  logic                  higher_zero_c;
  logic [NIB_W-1:0]      nib_c;
  logic [SEG_W-1:0]      glyph_c;

  assign wrap_c = enable && (cnt_q == CNT_LAST) && (idx_q == IDX_LAST);

  // Pick current digit; blank it when it and every higher nibble are zero
  always_comb begin
    nib_c         = '0;
    dp_bit_c      = 1'b0;
    blank_c       = 1'b0;
    higher_zero_c = 1'b1;
    for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
      higher_zero_c = higher_zero_c && (disp_q[i*NIB_W +: NIB_W] == '0);
      if (IDX_W'(i) == idx_q) begin
        nib_c    = disp_q[i*NIB_W +: NIB_W];
        dp_bit_c = disp_dp_q[i];
        blank_c  = lz_blank && higher_zero_c && (i != 0);
      end
    end
  end

  hex_seg_decode u_dec (
    .nib_i     (nib_c),
    .glyph_c_o (glyph_c)
  );

`ifdef SEG_BRIGHTNESS_EN
  assign slot_on_c = (cnt_q != '0) &&
                     ((32'(cnt_q) * 32'd16) < ((32'(bright) + 32'd1) * 32'(PRESCALE)));
`else
  assign slot_on_c = (cnt_q != '0);
`endif

  // Scan counters, frame-synchronous display update and registered outputs
  always_comb begin
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shadow_d    = shadow_q;
    shadow_dp_d = shadow_dp_q;
    disp_d      = disp_q;
    disp_dp_d   = disp_dp_q;
    pending_d   = pending_q;
    seg_d       = SEG_ALL_OFF_HI ^ SEG_INV;
    dp_d        = SEG_ACTIVE_LOW;
    dig_d       = DIG_INV;
    frame_d     = wrap_c;

    if (enable) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
        idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    if (load) begin
      shadow_d    = value;
      shadow_dp_d = dp_in;
    end

    // A load landing on the wrap bypasses the shadow so it shows this frame
    if (wrap_c) begin
      if (load) begin
        disp_d    = value;
        disp_dp_d = dp_in;
      end else if (pending_q) begin
        disp_d    = shadow_q;
        disp_dp_d = shadow_dp_q;
      end
      pending_d = 1'b0;
    end else if (load) begin
      pending_d = 1'b1;
    end

    if (enable) begin
      seg_d = (blank_c ? SEG_ALL_OFF_HI : glyph_c) ^ SEG_INV;
      dp_d  = dp_bit_c ^ SEG_ACTIVE_LOW;
      if (slot_on_c) dig_d = (NUM_DIGITS'(1) << idx_q) ^ DIG_INV;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      idx_q       <= '0;
      shadow_q    <= '0;
      shadow_dp_q <= '0;
      disp_q      <= '0;
      disp_dp_q   <= '0;
      pending_q   <= 1'b0;
      seg_q       <= SEG_ALL_OFF_HI ^ SEG_INV;
      dp_q        <= SEG_ACTIVE_LOW;
      dig_q       <= DIG_INV;
      frame_q     <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shadow_q    <= shadow_d;
      shadow_dp_q <= shadow_dp_d;
      disp_q      <= disp_d;
      disp_dp_q   <= disp_dp_d;
      pending_q   <= pending_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
      dig_q       <= dig_d;
      frame_q     <= frame_d;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign dig_sel    = dig_q;
  assign frame_done = frame_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver (4 digits, prescale 4, active-low pins).
module tb_seg_scan_driver;

  localparam int unsigned N = 4;
  localparam int unsigned P = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        enable = 1'b0;
  logic        load = 1'b0;
  logic        lz_blank = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp_in = '0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  dig_sel;
  logic        frame_done;
`ifdef SEG_BRIGHTNESS_EN
  logic [3:0]  bright = 4'hF;
`endif

  seg_scan_driver #(
    .NUM_DIGITS(N), .PRESCALE(P), .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .value(value),
    .dp_in(dp_in), .lz_blank(lz_blank),
`ifdef SEG_BRIGHTNESS_EN
    .bright(bright),
`endif
    .seg(seg), .dp(dp), .dig_sel(dig_sel), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;
  logic [12:0] exp_q[$];

  // Reference model state (pre-edge)
  int          m_cnt, m_idx;
  logic [15:0] m_sh, m_disp;
  logic [3:0]  m_shdp, m_ddp;
  logic        m_pend;

  // Last observation and the model slot it belongs to
  logic [6:0] o_seg;
  logic       o_dp, o_fd;
  logic [3:0] o_dig;
  int         o_idx, o_cnt;

  logic [6:0] glyph [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                             7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] want);
    n_checks++;
    assert (got === want) n_pass++;
    else $error("FAIL %s: observed %h, expected %h", tag, got, want);
  endtask

  function automatic logic [12:0] model_out();
    logic [12:0] r;
    logic        hz, blank;
    logic [3:0]  nib;
    if (!enable) return {1'b0, 4'hF, 1'b1, 7'h7F};
    hz = 1'b1;
    blank = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      hz = hz && (m_disp[i*4 +: 4] == 4'h0);
      if (i == m_idx) blank = lz_blank && hz && (i != 0);
    end
    nib = m_disp[m_idx*4 +: 4];
    r[6:0]  = blank ? 7'h7F : ~glyph[nib];
    r[7]    = ~m_ddp[m_idx];
    r[11:8] = (m_cnt == 0) ? 4'hF : ~(4'b0001 << m_idx);
    r[12]   = (m_cnt == P - 1) && (m_idx == N - 1);
    return r;
  endfunction

  task automatic model_step();
    logic wrap;
    wrap = enable && (m_cnt == P - 1) && (m_idx == N - 1);
    if (wrap) begin
      if (load) begin m_disp = value; m_ddp = dp_in; end
      else if (m_pend) begin m_disp = m_sh; m_ddp = m_shdp; end
      m_pend = 1'b0;
    end else if (load) begin
      m_pend = 1'b1;
    end
    if (load) begin m_sh = value; m_shdp = dp_in; end
    if (enable) begin
      if (m_cnt == P - 1) begin
        m_cnt = 0;
        m_idx = (m_idx == N - 1) ? 0 : m_idx + 1;
      end else begin
        m_cnt++;
      end
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_idx = 0; m_sh = '0; m_disp = '0;
    m_shdp = '0; m_ddp = '0; m_pend = 1'b0;
    exp_q.delete();
  endtask

  // One clock: push expectation, clock, pop and compare
  task automatic cyc();
    logic [12:0] e, o;
    exp_q.push_back(model_out());
    o_idx = m_idx;
    o_cnt = m_cnt;
    model_step();
    @(posedge clk);
    #1;
    o = {frame_done, dig_sel, dp, seg};
    {o_fd, o_dig, o_dp, o_seg} = o;
    e = exp_q.pop_front();
    check($sformatf("scan idx%0d cnt%0d", o_idx, o_cnt), 16'(o), 16'(e));
  endtask

  task automatic run_until(input int idx, input int cnt);
    int k;
    k = 0;
    do begin cyc(); k++; end
    while (!(o_idx == idx && o_cnt == cnt) && k < 64);
    check("reach slot", 16'(o_idx * 16 + o_cnt), 16'(idx * 16 + cnt));
  endtask

  task automatic wait_wrap();
    int k;
    k = 0;
    do begin cyc(); k++; end
    while (!o_fd && k < 64);
    check("frame wrap seen", 16'(o_fd), 16'(1));
  endtask

  // Assert reset mid-cycle, check outputs drop immediately, release mid-cycle
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("reset seg", 16'(seg), 16'h7F);
    check("reset dp", 16'(dp), 16'h1);
    check("reset dig_sel", 16'(dig_sel), 16'hF);
    check("reset frame_done", 16'(frame_done), 16'h0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  initial begin
    int k;
    #2;
    do_reset();
    enable = 1'b1;

    k = 0;
    do begin cyc(); k++; end
    while (!o_fd && k < 40);
    check("first frame_done clocks", 16'(k), 16'd16);

    // 1234 shown from the next frame
    value = 16'h1234; load = 1'b1; cyc(); load = 1'b0;
    wait_wrap();
    run_until(0, 0);
    check("count0 dig_sel", 16'(o_dig), 16'hF);
    cyc();
    check("d0 dig_sel", 16'(o_dig), 16'hE);
    check("d0 seg 4", 16'(o_seg), 16'h4C);
    run_until(3, 0);
    check("count0 dig_sel d3", 16'(o_dig), 16'hF);
    cyc();
    check("d3 dig_sel", 16'(o_dig), 16'h7);
    check("d3 seg 1", 16'(o_seg), 16'h4F);

    // Leading-zero suppression on 0080, dp survives on blanked digit 3
    value = 16'h0080; dp_in = 4'b1000; lz_blank = 1'b1;
    load = 1'b1; cyc(); load = 1'b0;
    wait_wrap();
    run_until(0, 1); check("lz d0 seg", 16'(o_seg), 16'h01);
    run_until(1, 1); check("lz d1 seg", 16'(o_seg), 16'h00);
    run_until(2, 1); check("lz d2 seg", 16'(o_seg), 16'h7F);
    run_until(3, 1); check("lz d3 seg", 16'(o_seg), 16'h7F);
    check("lz d3 dp", 16'(o_dp), 16'h0);

    // Mid-frame load stays hidden until the wrap
    wait_wrap();
    run_until(1, 0);
    value = 16'hAAAA; dp_in = 4'b0000; lz_blank = 1'b0;
    load = 1'b1; cyc(); load = 1'b0;
    run_until(2, 1); check("midframe d2 old", 16'(o_seg), 16'h01);
    run_until(3, 1); check("midframe d3 old", 16'(o_seg), 16'h01);
    wait_wrap();
    run_until(0, 1); check("newframe d0 A", 16'(o_seg), 16'h08);

    // Load on the wrap edge bypasses straight to display
    run_until(3, 2);
    value = 16'h5678; load = 1'b1; cyc(); load = 1'b0;
    check("coincident frame_done", 16'(o_fd), 16'h1);
    run_until(0, 1); check("bypass d0 8", 16'(o_seg), 16'h00);
    run_until(1, 1); check("bypass d1 7", 16'(o_seg), 16'h0F);

    // Pause scanning for 10 cycles, resume in the same slot
    run_until(2, 2);
    enable = 1'b0;
    for (int i = 0; i < 10; i++) cyc();
    check("paused dig_sel", 16'(o_dig), 16'hF);
    check("paused seg", 16'(o_seg), 16'h7F);
    check("paused slot held", 16'(o_idx * 16 + o_cnt), 16'h23);
    enable = 1'b1;
    cyc();
    check("resume dig_sel", 16'(o_dig), 16'hB);
    check("resume seg 6", 16'(o_seg), 16'h20);

    // Reset mid-frame drops a pending load
    value = 16'h9999; load = 1'b1; cyc(); load = 1'b0;
    cyc();
    #2;
    do_reset();
    wait_wrap();
    run_until(0, 1);
    check("pending lost d0", 16'(o_seg), 16'h01);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
